// File: rtl/alu_mc_pkg.sv
// Shared encodings for the multi-cycle execute ALU: opcodes, branch conditions,
// FSM states and the mul/div sub-operation selector.
package alu_mc_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SRL    = 5'd3,
    OP_SRA    = 5'd4,
    OP_AND    = 5'd5,
    OP_OR     = 5'd6,
    OP_XOR    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } op_e;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_JMP  = 3'b010;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // bit 1 selects divide, bit 0 selects the high product / remainder
  localparam logic [1:0] MD_MUL_LO = 2'b00;
  localparam logic [1:0] MD_MUL_HI = 2'b01;
  localparam logic [1:0] MD_DIV_Q  = 2'b10;
  localparam logic [1:0] MD_DIV_R  = 2'b11;

endpackage

// File: rtl/alu_mc_muldiv_iter.sv
// Iterative 1-bit/cycle multiplier (shift-add) and restoring divider on operand
// magnitudes; signs and divide-by-zero are fixed up in the final step.
module muldiv_iter
  import alu_mc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic            i_a_signed,
  input  logic            i_b_signed,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(XLEN - 1);

  logic            r_busy;
  logic [SHW:0]    r_cnt;
  logic [1:0]      r_op;
  logic            r_neg_p;
  logic            r_neg_r;
  logic            r_dz;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;

  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_qbit;
  logic [XLEN-1:0] w_nhi;
  logic [XLEN-1:0] w_nlo;
  logic [2*XLEN-1:0] w_prod_s;

  assign w_a_neg = i_a_signed & i_a[XLEN-1];
  assign w_b_neg = i_b_signed & i_b[XLEN-1];

  // r_hi is the product high half / partial remainder, r_lo the multiplier / dividend-quotient
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
  assign w_shift = {r_hi, r_lo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_b};
  assign w_qbit  = ~w_diff[XLEN];

  always_comb begin
    if (r_op[1]) begin
      w_nhi = w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
      w_nlo = {r_lo[XLEN-2:0], w_qbit};
    end else begin
      w_nhi = w_sum[XLEN:1];
      w_nlo = {w_sum[0], r_lo[XLEN-1:1]};
    end
  end

  assign w_prod_s = r_neg_p ? -{w_nhi, w_nlo} : {w_nhi, w_nlo};

  always_comb begin
    o_result = '0;
    case (r_op)
      MD_MUL_LO: o_result = w_prod_s[XLEN-1:0];
      MD_MUL_HI: o_result = w_prod_s[2*XLEN-1:XLEN];
      MD_DIV_Q:  o_result = r_dz ? {XLEN{1'b1}} : (r_neg_p ? -w_nlo : w_nlo);
      MD_DIV_R:  o_result = r_dz ? r_a : (r_neg_r ? -w_nhi : w_nhi);
      default:   o_result = '0;
    endcase
  end

  assign o_done = r_busy && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_op    <= MD_MUL_LO;
      r_neg_p <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (i_flush) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_busy  <= 1'b1;
      r_cnt   <= '0;
      r_op    <= i_op;
      r_neg_p <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_dz    <= (i_b == '0);
      r_a     <= i_a;
      r_b     <= w_b_neg ? -i_b : i_b;
      r_hi    <= '0;
      r_lo    <= w_a_neg ? -i_a : i_a;
    end else if (r_busy) begin
      r_hi <= w_nhi;
      r_lo <= w_nlo;
      if (r_cnt == CNT_LAST) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// EX-stage ALU: single-cycle base ops and branch compare, iterative RV32M ops,
// with valid/ready flow control and registered outputs.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESETN,
  input  logic            FLUSH,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [4:0]      CTRL,
  input  logic [2:0]      BRANCHCONDITION,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] OUT,
  output logic            BRANCHFLAG,
  output logic            BUSY,
  output logic [1:0]      DBG_STATE
);

  // Handshake: an op transfers on a rising edge with IN_VALID && IN_READY;
  // a result transfers on a rising edge with OUT_VALID && OUT_READY.
  localparam int SHW = $clog2(XLEN);

  state_e          r_state;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [XLEN-1:0] r_out;
  logic            r_bflag;
  logic            r_busy;

  logic [SHW-1:0]  w_sh;
  logic [XLEN-1:0] w_alu;
  logic            w_bflag;
  logic            w_is_mul;
  logic            w_is_div;
  logic            w_accept;
  logic            w_md_start;
  logic [1:0]      w_md_op;
  logic            w_a_s;
  logic            w_b_s;
  logic            w_md_done;
  logic [XLEN-1:0] w_md_res;

  assign w_sh       = B[SHW-1:0];
  assign w_is_mul   = (CTRL >= OP_MUL) && (CTRL <= OP_MULHU);
  assign w_is_div   = (CTRL >= OP_DIV) && (CTRL <= OP_REMU);
  assign w_accept   = r_in_ready && IN_VALID;
  assign w_md_start = w_accept && (w_is_mul || w_is_div) && !FLUSH;

  always_comb begin
    w_alu = '0;
    case (CTRL)
      OP_ADD:  w_alu = A + B;
      OP_SUB:  w_alu = A - B;
      OP_SLL:  w_alu = A << w_sh;
      OP_SRL:  w_alu = A >> w_sh;
      OP_SRA:  w_alu = $signed(A) >>> w_sh;
      OP_AND:  w_alu = A & B;
      OP_OR:   w_alu = A | B;
      OP_XOR:  w_alu = A ^ B;
      OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, (A < B)};
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_bflag = 1'b0;
    case (BRANCHCONDITION)
      BR_BEQ:  w_bflag = (A == B);
      BR_BNE:  w_bflag = (A != B);
      BR_BLT:  w_bflag = ($signed(A) < $signed(B));
      BR_BGE:  w_bflag = ($signed(A) >= $signed(B));
      BR_BLTU: w_bflag = (A < B);
      BR_BGEU: w_bflag = (A >= B);
      BR_JMP:  w_bflag = 1'b1;
      default: w_bflag = 1'b0;
    endcase
  end

  always_comb begin
    w_md_op = MD_MUL_LO;
    w_a_s   = 1'b1;
    w_b_s   = 1'b1;
    case (CTRL)
      OP_MULH:   w_md_op = MD_MUL_HI;
      OP_MULHSU: begin w_md_op = MD_MUL_HI; w_b_s = 1'b0; end
      OP_MULHU:  begin w_md_op = MD_MUL_HI; w_a_s = 1'b0; w_b_s = 1'b0; end
      OP_DIV:    w_md_op = MD_DIV_Q;
      OP_DIVU:   begin w_md_op = MD_DIV_Q; w_a_s = 1'b0; w_b_s = 1'b0; end
      OP_REM:    w_md_op = MD_DIV_R;
      OP_REMU:   begin w_md_op = MD_DIV_R; w_a_s = 1'b0; w_b_s = 1'b0; end
      default:   w_md_op = MD_MUL_LO;
    endcase
  end

  muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk        (CLK),
    .rst_n      (RESETN),
    .i_flush    (FLUSH),
    .i_start    (w_md_start),
    .i_op       (w_md_op),
    .i_a_signed (w_a_s),
    .i_b_signed (w_b_s),
    .i_a        (A),
    .i_b        (B),
    .o_done     (w_md_done),
    .o_result   (w_md_res)
  );

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_bflag     <= 1'b0;
      r_busy      <= 1'b0;
    end else if (FLUSH) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_in_ready <= 1'b0;
            r_bflag    <= w_bflag;
            if (w_is_mul) begin
              r_state <= ST_MUL;
              r_busy  <= 1'b1;
            end else if (w_is_div) begin
              r_state <= ST_DIV;
              r_busy  <= 1'b1;
            end else begin
              r_state     <= ST_DONE;
              r_out       <= w_alu;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (w_md_done) begin
            r_state     <= ST_DONE;
            r_out       <= w_md_res;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        ST_DONE: begin
          if (OUT_READY) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign IN_READY   = r_in_ready;
  assign OUT_VALID  = r_out_valid;
  assign OUT        = r_out;
  assign BRANCHFLAG = r_bflag;
  assign BUSY       = r_busy;
  assign DBG_STATE  = r_state;

endmodule

// File: tb/tb_alu_mc.sv
// Directed and randomized checks of alu_mc against an arithmetic reference model.
module tb_alu_mc;

  logic        CLK;
  logic        RESETN;
  logic        FLUSH;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  CTRL;
  logic [2:0]  BRANCHCONDITION;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT;
  logic        BRANCHFLAG;
  logic        BUSY;
  logic [1:0]  DBG_STATE;

  int total = 0;
  int bad = 0;
  logic [31:0] last_out = 32'h0;
  logic [31:0] exp_q[$];

  alu_mc #(.XLEN(32)) dut (
    .CLK(CLK), .RESETN(RESETN), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .CTRL(CTRL), .BRANCHCONDITION(BRANCHCONDITION), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT(OUT), .BRANCHFLAG(BRANCHFLAG), .BUSY(BUSY), .DBG_STATE(DBG_STATE)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] ref_alu(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    int sh;
    sh = int'(b[4:0]);
    r = 32'h0;
    case (c)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a << sh;
      5'd3:  r = a >> sh;
      5'd4:  begin p = {{32{a[31]}}, a} >> sh; r = p[31:0]; end
      5'd5:  r = a & b;
      5'd6:  r = a | b;
      5'd7:  r = a ^ b;
      5'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd9:  r = (a < b) ? 32'd1 : 32'd0;
      5'd10: begin p = {32'h0, a} * {32'h0, b}; r = p[31:0]; end
      5'd11: begin p = longint'($signed(a)) * longint'($signed(b)); r = p[63:32]; end
      5'd12: begin p = longint'($signed(a)) * longint'({32'h0, b}); r = p[63:32]; end
      5'd13: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
      5'd14: begin
        if (b == 32'h0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = $signed(a) / $signed(b);
      end
      5'd15: begin
        if (b == 32'h0) r = 32'hFFFF_FFFF;
        else r = a / b;
      end
      5'd16: begin
        if (b == 32'h0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else r = $signed(a) % $signed(b);
      end
      5'd17: begin
        if (b == 32'h0) r = a;
        else r = a % b;
      end
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic ref_br(input logic [2:0] bc, input logic [31:0] a, input logic [31:0] b);
    case (bc)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return $signed(a) < $signed(b);
      3'b101: return $signed(a) >= $signed(b);
      3'b110: return a < b;
      3'b111: return a >= b;
      3'b010: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: present one op and complete the handshake
  task automatic start_op(input logic [4:0] c, input logic [2:0] bc, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    @(negedge CLK);
    while (!IN_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("in_ready_before_op", 32'(IN_READY), 32'd1);
    CTRL = c; BRANCHCONDITION = bc; A = a; B = b; IN_VALID = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    A = $urandom; B = $urandom; CTRL = 5'($urandom); BRANCHCONDITION = 3'($urandom);
  endtask

  task automatic run_op(input string tag, input logic [4:0] c, input logic [2:0] bc,
                        input logic [31:0] a, input logic [31:0] b, input int hold);
    int lat;
    int exp_lat;
    logic exp_b;
    exp_q.push_back(ref_alu(c, a, b));
    exp_b = ref_br(bc, a, b);
    exp_lat = (c >= 5'd10 && c <= 5'd17) ? 33 : 1;
    start_op(c, bc, a, b);
    if (exp_lat > 1) chk({tag, "_busy"}, 32'(BUSY), 32'd1);
    lat = 1;
    while (!OUT_VALID && lat < 200) begin
      @(negedge CLK);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_out"}, OUT, exp_q[0]);
    chk({tag, "_bflag"}, 32'(BRANCHFLAG), 32'(exp_b));
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      chk({tag, "_hold_out"}, OUT, exp_q[0]);
      chk({tag, "_hold_in_ready"}, 32'(IN_READY), 32'd0);
      chk({tag, "_hold_valid"}, 32'(OUT_VALID), 32'd1);
    end
    last_out = exp_q.pop_front();
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
    chk({tag, "_valid_drop"}, 32'(OUT_VALID), 32'd0);
  endtask

  initial begin
    int seen;
    logic [4:0] rc;
    RESETN = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    A = '0; B = '0; CTRL = '0; BRANCHCONDITION = '0;

    // reset with random inputs applied
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      A = $urandom; B = $urandom; CTRL = 5'($urandom); BRANCHCONDITION = 3'($urandom);
      IN_VALID = 1'($urandom); OUT_READY = 1'($urandom); FLUSH = 1'($urandom);
    end
    chk("rst_out", OUT, 32'h0);
    chk("rst_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_bflag", 32'(BRANCHFLAG), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    IN_VALID = 1'b0; OUT_READY = 1'b0; FLUSH = 1'b0;
    RESETN = 1'b1;
    @(negedge CLK);
    chk("rst_in_ready", 32'(IN_READY), 32'd1);

    // directed base ops
    run_op("add_wrap", 5'd0, 3'b011, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sub", 5'd1, 3'b011, 32'd5, 32'd7, 0);
    run_op("sll_mask", 5'd2, 3'b011, 32'd1, 32'h21, 0);
    run_op("sra", 5'd4, 3'b011, 32'h8000_0000, 32'd4, 0);
    run_op("slt_ovf", 5'd8, 3'b011, 32'h8000_0000, 32'd1, 0);
    run_op("sltu", 5'd9, 3'b011, 32'h8000_0000, 32'd1, 0);
    run_op("undef_ctrl", 5'd20, 3'b011, 32'h1234_5678, 32'h9, 0);

    // directed M ops
    run_op("mulh", 5'd11, 3'b011, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("mulhu", 5'd13, 3'b011, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("mul", 5'd10, 3'b011, 32'd7, 32'hFFFF_FFFD, 0);
    run_op("mulhsu", 5'd12, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("div_by0", 5'd14, 3'b011, 32'd7, 32'd0, 0);
    run_op("rem_by0", 5'd16, 3'b011, 32'd7, 32'd0, 0);
    run_op("div_ovf", 5'd14, 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf", 5'd16, 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("divu", 5'd15, 3'b011, 32'd100, 32'd7, 0);
    run_op("remu", 5'd17, 3'b011, 32'd100, 32'd7, 0);
    run_op("div_neg", 5'd14, 3'b011, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("rem_neg", 5'd16, 3'b011, 32'hFFFF_FFF9, 32'd2, 0);

    // branch flag
    run_op("blt", 5'd0, 3'b100, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("bltu", 5'd0, 3'b110, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("beq", 5'd0, 3'b000, 32'd5, 32'd5, 0);
    run_op("bne", 5'd0, 3'b001, 32'd5, 32'd5, 0);
    run_op("jmp", 5'd0, 3'b010, 32'd3, 32'd9, 0);
    run_op("bge_mul", 5'd10, 3'b101, 32'd3, 32'hFFFF_FFFF, 0);

    // consumer stall
    run_op("hold_base", 5'd7, 3'b111, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 10);
    run_op("hold_mul", 5'd10, 3'b000, 32'd12345, 32'd678, 10);

    // flush in the middle of a divide
    start_op(5'd14, 3'b010, 32'd1000, 32'd3);
    repeat (11) @(negedge CLK);
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    chk("flush_valid", 32'(OUT_VALID), 32'd0);
    chk("flush_busy", 32'(BUSY), 32'd0);
    chk("flush_in_ready", 32'(IN_READY), 32'd1);
    chk("flush_out_kept", OUT, last_out);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (OUT_VALID) seen++;
    end
    chk("flush_no_result", 32'(seen), 32'd0);
    run_op("after_flush", 5'd15, 3'b011, 32'd1000, 32'd3, 0);

    // reset pulse in the middle of a multiply
    start_op(5'd10, 3'b010, 32'hFFFF_0000, 32'h1111);
    repeat (10) @(negedge CLK);
    RESETN = 1'b0;
    #1;
    chk("midrst_out", OUT, 32'h0);
    chk("midrst_valid", 32'(OUT_VALID), 32'd0);
    chk("midrst_bflag", 32'(BRANCHFLAG), 32'd0);
    chk("midrst_busy", 32'(BUSY), 32'd0);
    @(negedge CLK);
    RESETN = 1'b1;
    @(negedge CLK);
    chk("midrst_in_ready", 32'(IN_READY), 32'd1);
    last_out = 32'h0;
    run_op("after_rst", 5'd10, 3'b011, 32'hFFFF_0000, 32'h1111, 0);

    // randomized ops
    for (int i = 0; i < 80; i++) begin
      rc = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(18, 31)) : 5'($urandom_range(0, 17));
      run_op("rand", rc, 3'($urandom), rnd_val(), rnd_val(), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
